// File: rtl/operand_fetch_if.sv
// Handshake and bus signals for operand fetch: decode-side input, register-file
// and data-memory read ports, and the execute-side output bundle.
interface operand_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [1:0]  in_srctype;
    logic [3:0]  in_src;
    logic [3:0]  in_daddr;
    logic [7:0]  in_imm8;

    logic [3:0]  rf_raddr_d;
    logic [3:0]  rf_raddr_s;
    logic [15:0] rf_rdata_d;
    logic [15:0] rf_rdata_s;

    logic [15:0] dm_addr;
    logic [15:0] dm_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_op;
    logic [3:0]  out_daddr;
    logic [15:0] out_dval;
    logic [15:0] out_sval;
    logic        out_halt;

    modport slave (
        input  in_valid, in_op, in_srctype, in_src, in_daddr, in_imm8,
        input  rf_rdata_d, rf_rdata_s, dm_rdata, out_ready,
        output in_ready, rf_raddr_d, rf_raddr_s, dm_addr,
        output out_valid, out_op, out_daddr, out_dval, out_sval, out_halt
    );

    modport master (
        output in_valid, in_op, in_srctype, in_src, in_daddr, in_imm8,
        output rf_rdata_d, rf_rdata_s, dm_rdata, out_ready,
        input  in_ready, rf_raddr_d, rf_raddr_s, dm_addr,
        input  out_valid, out_op, out_daddr, out_dval, out_sval, out_halt
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads register operands, resolves the source value
// (register, immediate or data memory) and holds a bundle for execute.
module operand_fetch (
    input  logic           clk,
    input  logic           reset,
    operand_fetch_if.slave bus
);

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        HALTED
    } state_e;

    state_e      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic        out_halt_q, out_halt_d;
    logic [5:0]  out_op_q, out_op_d;
    logic [3:0]  out_daddr_q, out_daddr_d;
    logic [15:0] out_dval_q, out_dval_d;
    logic [15:0] out_sval_q, out_sval_d;

    logic        is_imm8;
    logic        is_sys;
    logic        is_mem;
    logic [15:0] sval_direct;
    logic        accept;
    logic        out_xfer;
    logic        in_ready;

    assign bus.rf_raddr_d = bus.in_daddr;
    assign bus.rf_raddr_s = bus.in_src;

    // sys never issues a load; it always completes as a one-cycle bundle.
    always_comb begin
        is_imm8 = bus.in_op[5];
        is_sys  = (bus.in_op == 6'b000000);
        is_mem  = !is_imm8 && !is_sys && bus.in_srctype[1];

        sval_direct = bus.rf_rdata_s;
        if (is_imm8) begin
            sval_direct = {8'h00, bus.in_imm8};
        end else if (bus.in_srctype == 2'b01) begin
            sval_direct = {{12{bus.in_src[3]}}, bus.in_src};
        end
    end

    assign bus.dm_addr = bus.in_srctype[0] ? {12'h000, bus.in_src} : bus.rf_rdata_s;

    always_comb begin
        in_ready = 1'b0;
        if (state_q == RUN) begin
            in_ready = !out_valid_q || bus.out_ready;
        end
    end

    assign accept   = bus.in_valid && in_ready;
    assign out_xfer = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_halt_d  = out_halt_q;
        out_op_d    = out_op_q;
        out_daddr_d = out_daddr_q;
        out_dval_d  = out_dval_q;
        out_sval_d  = out_sval_q;

        unique case (state_q)
            RUN: begin
                if (accept) begin
                    out_op_d    = bus.in_op;
                    out_daddr_d = bus.in_daddr;
                    out_dval_d  = bus.rf_rdata_d;
                    out_halt_d  = is_sys;
                    if (is_mem) begin
                        out_valid_d = 1'b0;
                        state_d     = MEMWAIT;
                    end else begin
                        out_sval_d  = sval_direct;
                        out_valid_d = 1'b1;
                        if (is_sys) begin
                            state_d = HALTED;
                        end
                    end
                end else if (out_xfer) begin
                    out_valid_d = 1'b0;
                end
            end
            MEMWAIT: begin
                out_sval_d  = bus.dm_rdata;
                out_valid_d = 1'b1;
                state_d     = RUN;
            end
            HALTED: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            out_valid_q <= 1'b0;
            out_halt_q  <= 1'b0;
            out_op_q    <= '0;
            out_daddr_q <= '0;
            out_dval_q  <= '0;
            out_sval_q  <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_halt_q  <= out_halt_d;
            out_op_q    <= out_op_d;
            out_daddr_q <= out_daddr_d;
            out_dval_q  <= out_dval_d;
            out_sval_q  <= out_sval_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_halt  = out_halt_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_daddr = out_daddr_q;
    assign bus.out_dval  = out_dval_q;
    assign bus.out_sval  = out_sval_q;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameters: none; the data word is fixed at 16 bits and the register index at 4 bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on posedge clk only.
REQ-004 in_valid  input  1  the decode stage presents a decoded instruction this cycle.
REQ-005 in_ready  output  1  this block accepts the instruction this cycle.
REQ-006 in_op  input  6  decoded opcode; 8-bit-immediate forms arrive as {op4,2'b00}.
REQ-007 in_srctype  input  2  source type field.
REQ-008 in_src  input  4  source register index or 4-bit immediate.
REQ-009 in_daddr  input  4  destination register index.
REQ-010 in_imm8  input  8  8-bit immediate field, used only for 8-bit-immediate ops.
REQ-011 rf_raddr_d, rf_raddr_s  output  4 each  register-file read addresses.
REQ-012 rf_rdata_d, rf_rdata_s  input  16 each  combinational same-cycle register-file read data.
REQ-013 dm_addr  output  16  data-memory read address; dm_rdata is valid exactly one cycle after dm_addr is issued.
REQ-014 dm_rdata  input  16  data-memory read data.
REQ-015 out_valid  output  1  the output bundle is valid.
REQ-016 out_ready  input  1  the execute stage consumes the bundle.
REQ-017 out_op, out_daddr, out_dval, out_sval  output  6/4/16/16  opcode, destination index, destination value and resolved source value.
REQ-018 out_halt  output  1  the held bundle is a sys (halt) instruction.

Function
REQ-019 Transfer on input occurs when in_valid && in_ready; transfer on output occurs when out_valid && out_ready.
REQ-020 FSM states: RUN, MEMWAIT, HALTED.
REQ-021 RUN: in_ready = !out_valid || out_ready.
REQ-022 MEMWAIT: in_ready = 0.
REQ-023 HALTED: in_ready = 0.
REQ-024 rf_raddr_d = in_daddr and rf_raddr_s = in_src, both combinational.
REQ-025 Source resolution for srctype 00: sval = rf_rdata_s.
REQ-026 Source resolution for srctype 01: sval = in_src sign-extended to 16 bits.
REQ-027 Source resolution for srctype 10: sval = mem[rf_rdata_s].
REQ-028 Source resolution for srctype 11: sval = mem[{12'h000, in_src}].
REQ-029 For 8-bit-immediate ops (in_op[5] = 1), sval = {8'h00, in_imm8} and srctype is ignored.
REQ-030 Register or immediate source: the accept registers the bundle, and out_valid rises on the next cycle (1-cycle latency).
REQ-031 Memory source: the accept drives dm_addr in the same cycle, latches op, daddr and dval, and enters MEMWAIT.
REQ-032 The next cycle captures dm_rdata into out_sval, sets out_valid and returns to RUN (2-cycle latency).
REQ-033 dm_addr is don't-care when no memory source is being accepted.
REQ-034 While out_valid && !out_ready, all out_* fields are held stable.
REQ-035 Back-to-back: an output transfer and a new accept may occur in the same cycle with no bubble for register or immediate sources.
REQ-036 If an output transfer occurs and no accept occurs in the same cycle, out_valid falls on the next cycle.
REQ-037 sys (in_op = 000000) is accepted as a normal bundle with out_halt = 1, and the FSM enters HALTED.
REQ-038 In HALTED, the held bundle drains normally once out_ready is asserted.
REQ-039 HALTED persists until reset; any in_valid presented during HALTED is ignored.
REQ-040 Opcode values are passed through unchanged; no opcode validity check is performed.

Reset
REQ-041 On reset: FSM = RUN, out_valid = 0, out_halt = 0, and out_op, out_daddr, out_dval, out_sval are cleared to 0.
REQ-042 in_ready equals 1 during the first cycle after reset is deasserted.
REQ-043 Reset asserted during MEMWAIT discards the pending load; the dm_rdata returned in that cycle is ignored.
REQ-044 Reset overrides any simultaneous input or output transfer.

Verification
REQ-045 Register source: reg3 = 16'h1234, reg2 = 16'h0005; add with daddr 2, src 3, srctype 00, out_ready = 1 -> next cycle out_valid = 1, out_sval = 1234, out_dval = 0005.
REQ-046 Immediate source: srctype 01, src 4'hE -> out_sval = FFFE; lhi with imm8 = 8'hA5 -> out_sval = 00A5.
REQ-047 Memory source: srctype 10, reg4 = 16'h0010, mem[0010] = 16'hBEEF -> in_ready = 0 for one cycle, then out_sval = BEEF two cycles after the accept.
REQ-048 Stall: out_ready held low for 3 cycles with in_valid = 1 -> out_* stable, in_ready = 0, no instruction lost or duplicated after release.
REQ-049 Halt: sys followed by add -> out_halt = 1 on the sys bundle, the add is never accepted, and in_ready stays 0 until reset.
REQ-050 Reset mid-load: reset asserted in MEMWAIT -> next cycle out_valid = 0, FSM = RUN, in_ready = 1.
